jtag_ahb_access_dr: RTL and testbench

//  JTAG data register giving the debug host single-beat AHB read/write access.
//  It sits between the TAP controller and the AHB master front-end, in the TCK domain.

---
 rtl/jtag_ahb_access_dr_if.sv | 27 ++
 rtl/jtag_ahb_access_dr.sv | 119 +++++++++++
 tb/tb_jtag_ahb_access_dr.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_ahb_access_dr_if.sv
// Single-beat request/response bundle between the JTAG AHB-access DR and the AHB master front-end.
// The DR drives the request and receives the response (master); the AHB front-end is the slave.
interface jtag_ahb_access_dr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [SIZE_W-1:0] req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/jtag_ahb_access_dr.sv
// JTAG data register issuing one AHB access per Update-DR; request is held until req_ready.
// Capture-DR returns {rdata_hold, overrun, error, done}; update->req_valid and rsp->done are 1 cycle.
module jtag_ahb_access_dr #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 2
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic                 tlr_reset,
  input  logic                 ahb_select,
  input  logic                 dr_capture,
  input  logic                 dr_shift,
  input  logic                 dr_update,
  input  logic                 TDI,
  output logic                 TDO,
  jtag_ahb_access_dr_if.master bus
);
  localparam int DR_W = 1 + SIZE_W + ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_DONE} state_e;

  state_e            state_q;
  logic [DR_W-1:0]   sr_q, sr_d, cap_word;
  logic [DATA_W-1:0] rdata_hold_q;
  logic              done_q, error_q, overrun_q;
  logic              req_valid_q, req_write_q;
  logic [SIZE_W-1:0] req_size_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  logic cap_en, shift_en, upd_en;
  assign cap_en   = ahb_select & dr_capture;
  assign shift_en = ahb_select & dr_shift;
  assign upd_en   = ahb_select & dr_update;

  // Capture has priority over a coincident shift.
  always_comb begin
    cap_word = '0;
    cap_word[DATA_W+2:0] = {rdata_hold_q, overrun_q, error_q, done_q};
    sr_d = sr_q;
    if (cap_en) begin
      sr_d = cap_word;
    end else if (shift_en) begin
      sr_d = {TDI, sr_q[DR_W-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      rdata_hold_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_size_q   <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
    end else if (tlr_reset) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      rdata_hold_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_size_q   <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
    end else begin
      sr_q <= sr_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          // Decode uses the pre-shift register contents.
          if (upd_en) begin
            req_valid_q <= 1'b1;
            req_write_q <= sr_q[0];
            req_size_q  <= sr_q[SIZE_W:1];
            req_addr_q  <= sr_q[ADDR_W+SIZE_W:SIZE_W+1];
            req_wdata_q <= sr_q[DR_W-1:ADDR_W+SIZE_W+1];
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            overrun_q   <= 1'b0;
            state_q     <= S_PEND;
          end
        end
        S_PEND: begin
          if (upd_en) overrun_q <= 1'b1;
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (upd_en) overrun_q <= 1'b1;
          if (bus.rsp_valid) begin
            done_q  <= 1'b1;
            error_q <= bus.rsp_error;
            // Failed reads keep the previous read data.
            if (!req_write_q && !bus.rsp_error) rdata_hold_q <= bus.rsp_rdata;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TDO           = sr_q[0];
  assign bus.req_valid = req_valid_q;
  assign bus.req_write = req_write_q;
  assign bus.req_size  = req_size_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
endmodule

// File: tb/tb_jtag_ahb_access_dr.sv
// Directed + randomized bench for jtag_ahb_access_dr against a transaction-level model
// of the sticky status, held read data and the issued request fields.
module tb_jtag_ahb_access_dr;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int DR_W   = 1 + SIZE_W + ADDR_W + DATA_W;

  logic TCK = 1'b0;
  logic TRST = 1'b0, tlr_reset = 1'b0, ahb_select = 1'b0;
  logic dr_capture = 1'b0, dr_shift = 1'b0, dr_update = 1'b0, TDI = 1'b0;
  logic TDO;

  jtag_ahb_access_dr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

  jtag_ahb_access_dr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .tlr_reset (tlr_reset),
    .ahb_select(ahb_select),
    .dr_capture(dr_capture),
    .dr_shift  (dr_shift),
    .dr_update (dr_update),
    .TDI       (TDI),
    .TDO       (TDO),
    .bus       (bus)
  );

  always #5 TCK = ~TCK;

  int errors = 0;
  int checks = 0;

  // Model: last shifted command, outstanding flag, sticky status, held read data, issued request.
  logic              c_write;
  logic [SIZE_W-1:0] c_size;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              m_busy, m_done, m_err, m_ovr;
  logic [DATA_W-1:0] m_rdata;
  logic              m_write;
  logic [SIZE_W-1:0] m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_ovr = 0; m_rdata = '0;
    m_write = 0; m_size = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic shift_in(input logic [DR_W-1:0] v);
    ahb_select = 1; dr_shift = 1;
    for (int i = 0; i < DR_W; i++) begin
      TDI = v[i];
      tick();
    end
    dr_shift = 0; TDI = 0;
  endtask

  task automatic shift_out(output logic [DR_W-1:0] v);
    ahb_select = 1; dr_shift = 1; TDI = 0;
    for (int i = 0; i < DR_W; i++) begin
      v[i] = TDO;
      tick();
    end
    dr_shift = 0;
  endtask

  task automatic shift_cmd(input logic w, input logic [SIZE_W-1:0] sz,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    c_write = w; c_size = sz; c_addr = a; c_wdata = d;
    shift_in({d, a, sz, w});
  endtask

  task automatic update(input string tag);
    ahb_select = 1; dr_update = 1;
    tick();
    dr_update = 0;
    if (!m_busy) begin
      m_busy = 1; m_done = 0; m_err = 0; m_ovr = 0;
      m_write = c_write; m_size = c_size; m_addr = c_addr; m_wdata = c_wdata;
      chk({tag, "_req_valid"}, bus.req_valid, 1'b1);
      chk({tag, "_req_fields"}, {bus.req_write, bus.req_size, bus.req_addr, bus.req_wdata},
          {m_write, m_size, m_addr, m_wdata});
    end else begin
      m_ovr = 1;
      chk({tag, "_req_unchanged"}, {bus.req_write, bus.req_size, bus.req_addr, bus.req_wdata},
          {m_write, m_size, m_addr, m_wdata});
    end
  endtask

  // Hold off req_ready for dly cycles (one of them carrying a stray response), then accept.
  task automatic handshake(input string tag, input int dly);
    int n = 0;
    int d = dly;
    while (bus.req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, bus.req_valid, 1'b1);
    if (d > 0) begin
      bus.rsp_valid = 1; bus.rsp_rdata = $urandom; bus.rsp_error = 1;
      tick();
      bus.rsp_valid = 0; bus.rsp_error = 0;
      d--;
    end
    repeat (d) tick();
    chk({tag, "_held"}, {bus.req_valid, bus.req_write, bus.req_size, bus.req_addr, bus.req_wdata},
        {1'b1, m_write, m_size, m_addr, m_wdata});
    bus.req_ready = 1;
    tick();
    bus.req_ready = 0;
    chk({tag, "_valid_drop"}, bus.req_valid, 1'b0);
    bus.req_ready = 1;
    tick();
    bus.req_ready = 0;
  endtask

  task automatic respond(input logic [DATA_W-1:0] rd, input logic er);
    bus.rsp_valid = 1; bus.rsp_rdata = rd; bus.rsp_error = er;
    tick();
    bus.rsp_valid = 0; bus.rsp_error = 0;
    m_done = 1; m_err = er; m_busy = 0;
    if (!m_write && !er) m_rdata = rd;
  endtask

  task automatic capture_check(input string tag);
    logic [DATA_W+2:0] got;
    ahb_select = 1; dr_capture = 1;
    tick();
    dr_capture = 0; dr_shift = 1; TDI = 0;
    for (int i = 0; i < DATA_W + 3; i++) begin
      got[i] = TDO;
      tick();
    end
    dr_shift = 0;
    chk({tag, "_status"}, got[2:0], {m_ovr, m_err, m_done});
    chk({tag, "_rdata"}, got[DATA_W+2:3], m_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DR_W-1:0]   pat, rb;
    logic [DATA_W-1:0] rd;
    logic              pre_valid;
    bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = '0; bus.rsp_error = 0;
    model_reset();
    c_write = 0; c_size = '0; c_addr = '0; c_wdata = '0;

    // Reset state
    #1;
    chk("rst_tdo", TDO, 1'b0);
    chk("rst_req", {bus.req_valid, bus.req_write, bus.req_size, bus.req_addr, bus.req_wdata}, '0);
    tick(); tick();
    TRST = 1;
    tick();

    // Write
    shift_cmd(1'b1, 2'd2, 32'h4000_0010, 32'hDEAD_BEEF);
    update("wr");
    handshake("wr", 3);
    respond($urandom, 1'b0);
    capture_check("wr_cap");

    // Read
    shift_cmd(1'b0, 2'd2, 32'h2000_0000, 32'h0);
    update("rd");
    handshake("rd", 1);
    respond(32'hCAFE_F00D, 1'b0);
    capture_check("rd_cap");

    // Overrun: second update while pending
    shift_cmd(1'b0, 2'd1, 32'h1000_0040, 32'h0);
    update("ov1");
    shift_cmd(1'b1, 2'd0, 32'h5555_0000, 32'h1234_5678);
    update("ov2");
    handshake("ov", 2);
    respond($urandom, 1'b0);
    capture_check("ov_cap");
    shift_cmd(1'b0, 2'd2, 32'h1000_0080, 32'h0);
    update("ov3");
    capture_check("ov_clr");
    handshake("ov3", 0);
    respond($urandom, 1'b0);

    // Error on read keeps held data
    shift_cmd(1'b0, 2'd2, 32'h3000_0000, 32'h0);
    update("er");
    handshake("er", 1);
    respond($urandom, 1'b1);
    capture_check("er_cap");

    // Deselected strobes have no effect
    pat = {$urandom, $urandom, $urandom};
    shift_in(pat);
    pre_valid = bus.req_valid;
    ahb_select = 0; dr_capture = 1; dr_shift = 1; dr_update = 1; TDI = ~pat[0];
    tick();
    dr_capture = 0; dr_update = 0;
    tick();
    dr_shift = 0; dr_update = 1;
    tick();
    dr_update = 0;
    chk("sel_tdo", TDO, pat[0]);
    chk("sel_req_valid", bus.req_valid, pre_valid);
    shift_out(rb);
    chk("sel_sr", rb, pat);

    // TRST while pending and while waiting
    shift_cmd(1'b1, 2'd2, 32'h0BAD_0000, $urandom);
    update("trp");
    TRST = 0;
    #1;
    chk("trst_pend_valid", bus.req_valid, 1'b0);
    model_reset();
    tick();
    TRST = 1;
    shift_cmd(1'b1, 2'd2, 32'h0BAD_0004, $urandom);
    update("trw");
    handshake("trw", 0);
    chk("trst_pre_tdo", TDO, 1'b1);
    TRST = 0;
    #1;
    chk("trst_tdo", TDO, 1'b0);
    chk("trst_req", {bus.req_valid, bus.req_addr}, '0);
    model_reset();
    tick();
    TRST = 1;
    bus.rsp_valid = 1; bus.rsp_rdata = $urandom;
    tick();
    bus.rsp_valid = 0;
    capture_check("trst_cap");

    // Test-Logic-Reset while waiting: takes effect at the next edge
    shift_cmd(1'b1, 2'd1, 32'h0BAD_0008, $urandom);
    update("tlr");
    handshake("tlr", 0);
    tlr_reset = 1;
    #1;
    chk("tlr_pre_tdo", TDO, 1'b1);
    tick();
    tlr_reset = 0;
    chk("tlr_tdo", TDO, 1'b0);
    chk("tlr_req", {bus.req_valid, bus.req_addr}, '0);
    model_reset();
    bus.rsp_valid = 1; bus.rsp_rdata = $urandom;
    tick();
    bus.rsp_valid = 0;
    capture_check("tlr_cap");

    // Randomized transactions
    for (int t = 0; t < 10; t++) begin
      shift_cmd(1'($urandom), SIZE_W'($urandom), $urandom, $urandom);
      update("rnd");
      if ($urandom_range(0, 2) == 0) update("rnd_ov");
      handshake("rnd", $urandom_range(0, 4));
      rd = $urandom;
      respond(rd, ($urandom_range(0, 3) == 0));
      capture_check("rnd_cap");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
